axis_hdr_strip: RTL and testbench

Receive-side counterpart of the header inserter on the AXI-Stream loopback path. Each inbound frame starts with one 32-bit header word. The block consumes and checks that header, forwards only the payload beats downstream with TLAST preserved, and reports per-frame status. Frames with a bad magic are dropped whole.

---
 rtl/axis_pkg.sv | 33 +++
 rtl/axis_reg_slice.sv | 55 +++++
 rtl/axis_hdr_strip.sv | 138 +++++++++++++
 tb/tb_axis_hdr_strip.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Purpose: shared header layout, default magic and strip-FSM encoding for the AXIS loopback path.
// Latency: none (definitions only).
// Backpressure: not applicable.
package axis_pkg;

  // Header word layout: magic in the upper half, payload beat count in the lower half.
  localparam int MAGIC_MSB = 31;
  localparam int MAGIC_LSB = 16;
  localparam int LEN_MSB   = 15;
  localparam int LEN_LSB   = 0;
  localparam int HDR_WIDTH = 32;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hA55A;

  // Strip FSM encoding, kept as plain constants so older tools can share it.
  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef struct packed {
    logic [MAGIC_MSB-MAGIC_LSB:0] magic;
    logic [LEN_MSB-LEN_LSB:0]     len;
  } hdr_t;

  // Splits a raw header word into its fields using the positions above.
  function automatic hdr_t hdr_from_word(input logic [HDR_WIDTH-1:0] w);
    hdr_t h;
    h.magic = w[MAGIC_MSB:MAGIC_LSB];
    h.len   = w[LEN_MSB:LEN_LSB];
    return h;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Purpose: single-entry output register for an AXI-Stream beat (data + last).
// Latency: one cycle from input handshake to out_vld_o.
// Backpressure: in_rdy_o = !out_vld_o || out_rdy_i, so full rate while downstream is ready.
module axis_reg_slice #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  input  logic         in_last_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  output logic         out_last_o,
  input  logic         out_rdy_i
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;
  logic         last_q, last_d;

  assign in_rdy_o   = !vld_q || out_rdy_i;
  assign out_vld_o  = vld_q;
  assign out_dat_o  = dat_q;
  assign out_last_o = last_q;

  // Load on an accepted beat, otherwise empty once downstream takes the held beat.
  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    last_d = last_q;
    if (in_vld_i && in_rdy_o) begin
      vld_d  = 1'b1;
      dat_d  = in_dat_i;
      last_d = in_last_i;
    end else if (out_rdy_i) begin
      vld_d  = 1'b0;
    end
  end

  // Data/last only change on a load, so they stay stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/axis_hdr_strip.sv
// Purpose: consume and check the one-word frame header, forward payload, report per-frame status.
// Latency: one cycle input-to-output for payload; header takes one input cycle and emits nothing.
// Backpressure: ready is always 1 in HDR/DROP; in PASS it follows the output register's ready.
module axis_hdr_strip
  import axis_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [15:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  frame_ok,
  output logic                  err_magic,
  output logic                  err_len,
  output logic [15:0]           frame_cnt
);

  logic [1:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        ok_q, ok_d;
  logic        emag_q, emag_d;
  logic        elen_q, elen_d;

  hdr_t        hdr;
  logic        magic_ok;
  logic        in_hs;
  logic        slice_rdy;
  logic        slice_vld;
  logic [15:0] beat_inc;

  assign hdr      = hdr_from_word(s_axis_tdata[HDR_WIDTH-1:0]);
  assign magic_ok = (hdr.magic == MAGIC);

  // Only the PASS state feeds the output register; header and dropped beats never reach it.
  assign slice_vld     = (state_q == ST_PASS) && s_axis_tvalid;
  assign s_axis_tready = (state_q == ST_PASS) ? slice_rdy : 1'b1;
  assign in_hs         = s_axis_tvalid && s_axis_tready;

  // Beat count including the current beat, pinned at all-ones for very long frames.
  assign beat_inc = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;

  assign frame_ok  = ok_q;
  assign err_magic = emag_q;
  assign err_len   = elen_q;
  assign frame_cnt = frame_cnt_q;

  axis_reg_slice #(
    .W (DATA_WIDTH)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .in_vld_i   (slice_vld),
    .in_dat_i   (s_axis_tdata),
    .in_last_i  (s_axis_tlast),
    .in_rdy_o   (slice_rdy),
    .out_vld_o  (m_axis_tvalid),
    .out_dat_o  (m_axis_tdata),
    .out_last_o (m_axis_tlast),
    .out_rdy_i  (m_axis_tready)
  );

  // Frame FSM: header decode, payload length tracking and single-cycle status pulses.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    ok_d        = 1'b0;
    emag_d      = 1'b0;
    elen_d      = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (in_hs) begin
          len_d      = hdr.len;
          beat_cnt_d = '0;
          if (!magic_ok) begin
            emag_d  = 1'b1;
            state_d = s_axis_tlast ? ST_HDR : ST_DROP;
          end else if (!s_axis_tlast) begin
            state_d = ST_PASS;
          end else begin
            // Header-only frame: nothing to forward, length must have been zero.
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (hdr.len == 16'd0) ok_d   = 1'b1;
            else                  elen_d = 1'b1;
          end
        end
      end
      ST_PASS: begin
        if (in_hs) begin
          beat_cnt_d = beat_inc;
          if (s_axis_tlast) begin
            state_d     = ST_HDR;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (beat_inc == len_q) ok_d   = 1'b1;
            else                   elen_d = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (in_hs && s_axis_tlast) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  // Control/status registers; reset returns to header-hunting with cleared counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HDR;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      ok_q        <= 1'b0;
      emag_q      <= 1'b0;
      elen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ok_q        <= ok_d;
      emag_q      <= emag_d;
      elen_q      <= elen_d;
    end
  end

endmodule

// File: tb/tb_axis_hdr_strip.sv
// Purpose: randomized + directed scoreboard bench for axis_hdr_strip against a frame-level model.
// Latency: expectations are queued per frame and popped whenever the DUT presents output.
// Backpressure: downstream ready is driven always-on, random, patterned or held low.
module tb_axis_hdr_strip;

  localparam logic [15:0] GOOD = 16'hA55A;
  localparam int K_OK = 1, K_MAG = 2, K_LEN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        frame_ok, err_magic, err_len;
  logic [15:0] frame_cnt;

  typedef struct { logic [31:0] d; logic l; } beat_t;
  typedef struct { int kind; logic [15:0] cnt; } st_t;

  beat_t       exp_q[$];
  st_t         st_q[$];
  logic [31:0] pay_q[$];
  logic [15:0] cnt_model = '0;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;
  int pat_i = 0;
  bit stall_hold = 0;
  logic [31:0] hold_d;
  logic        hold_l;

  axis_hdr_strip #(.DATA_WIDTH(32), .MAGIC(16'hA55A)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .frame_ok      (frame_ok),
    .err_magic     (err_magic),
    .err_len       (err_len),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream ready: 0 always 1, 1 random, 2 pattern 1,0,0,1, 3 held low.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = 1'($urandom_range(0, 1));
      2: begin
        m_tready = (pat_i == 1 || pat_i == 2) ? 1'b0 : 1'b1;
        pat_i = (pat_i + 1) % 4;
      end
      default: m_tready = 1'b0;
    endcase
  end

  // Monitor: pops expected beats/status on every observed output, checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_hold = 0;
    end else begin
      if (m_tvalid) begin
        if (stall_hold) begin
          chk("stall_data_stable", m_tdata, hold_d);
          chk("stall_last_stable", 32'(m_tlast), 32'(hold_l));
        end
        if (m_tready) begin
          stall_hold = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(m_tvalid), 32'd0);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_data", m_tdata, e.d);
            chk("beat_last", 32'(m_tlast), 32'(e.l));
          end
        end else begin
          stall_hold = 1;
          hold_d = m_tdata;
          hold_l = m_tlast;
        end
      end else begin
        stall_hold = 0;
      end
      if (frame_ok || err_magic || err_len) begin
        int kind;
        kind = frame_ok ? K_OK : (err_magic ? K_MAG : K_LEN);
        chk("pulse_exclusive", 32'(frame_ok) + 32'(err_magic) + 32'(err_len), 32'd1);
        if (st_q.size() == 0) begin
          chk("unexpected_status", 32'(kind), 32'd0);
        end else begin
          st_t s;
          s = st_q.pop_front();
          chk("status_kind", 32'(kind), 32'(s.kind));
          chk("frame_cnt", 32'(frame_cnt), 32'(s.cnt));
        end
      end
    end
  end

  // Presents one beat and holds it until accepted; optionally requires ready on first look.
  task automatic send_beat(input logic [31:0] d, input logic l, input bit must_rdy);
    int  waitc = 0;
    bit  first = 1;
    bit  done = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (must_rdy && first) chk("s_tready_high", 32'(s_tready), 32'd1);
      first = 0;
      if (s_tready) begin
        done = 1;
      end else begin
        waitc++;
        if (waitc > 300) begin
          chk("s_tready_timeout", 32'(s_tready), 32'd1);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  // Frame-level reference: bad magic -> dropped; good -> all payload forwarded,
  // counter bumped, ok iff payload count equals header length. Payload comes from pay_q.
  task automatic run_frame(input logic [15:0] magic, input logic [15:0] n, input bit gaps);
    int  nb;
    bit  good;
    st_t s;
    nb   = pay_q.size();
    good = (magic == GOOD);
    if (good) begin
      for (int i = 0; i < nb; i++) exp_q.push_back('{d: pay_q[i], l: (i == nb - 1)});
      cnt_model = cnt_model + 16'd1;
      s.kind = (nb == int'(n)) ? K_OK : K_LEN;
    end else begin
      s.kind = K_MAG;
    end
    s.cnt = cnt_model;
    st_q.push_back(s);
    send_beat({magic, n}, nb == 0, 1'b1);
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_beat(pay_q[i], i == nb - 1, !good);
    end
    pay_q.delete();
  endtask

  task automatic drain();
    int c = 0;
    rdy_mode = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && c < 500) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_beats_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_status_empty", 32'(st_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_pulses", {29'd0, frame_ok, err_magic, err_len}, 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Nominal 4-beat frame
    pay_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_frame(GOOD, 16'd4, 0);
    drain();
    chk("frame_cnt_after_first", 32'(frame_cnt), 32'd1);

    // Bad magic dropped whole, then a good frame
    pay_q = '{32'h55, 32'h66};
    run_frame(16'hDEAD, 16'd2, 0);
    pay_q = '{32'h77, 32'h88};
    run_frame(GOOD, 16'd2, 0);
    drain();

    // Short and long frames still forwarded
    pay_q = '{32'hA1, 32'hA2};
    run_frame(GOOD, 16'd3, 0);
    pay_q = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
    run_frame(GOOD, 16'd3, 0);
    drain();

    // Stall pattern, then back-to-back frame
    rdy_mode = 2;
    pat_i = 0;
    pay_q = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    run_frame(GOOD, 16'd4, 0);
    pay_q = '{32'hD1, 32'hD2, 32'hD3};
    run_frame(GOOD, 16'd3, 0);
    drain();

    // Header-only frames
    run_frame(GOOD, 16'd0, 0);
    run_frame(GOOD, 16'd1, 0);
    run_frame(16'h1234, 16'd0, 0);
    drain();

    // Randomized frames with random backpressure and input gaps
    for (int f = 0; f < 150; f++) begin
      logic [15:0] mg, n;
      int nb;
      rdy_mode = $urandom_range(0, 1);
      mg = ($urandom_range(0, 3) == 0) ? 16'($urandom) : GOOD;
      if ($urandom_range(0, 3) == 0 && mg != GOOD) mg = ~GOOD;
      n  = 16'($urandom_range(0, 5));
      nb = ($urandom_range(0, 1) == 0) ? int'(n) : $urandom_range(0, 5);
      for (int i = 0; i < nb; i++) pay_q.push_back($urandom);
      run_frame(mg, n, 1);
    end
    drain();

    // Reset in the middle of a stalled frame
    rdy_mode = 3;
    @(posedge clk); #1;
    chk("pre_reset_cnt", 32'(frame_cnt), 32'(cnt_model));
    send_beat({GOOD, 16'd4}, 1'b0, 1'b1);
    send_beat(32'h0000_0AAA, 1'b0, 1'b0);
    s_tdata  = 32'h0000_0BBB;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    repeat (2) @(negedge clk);
    chk("stalled_m_tvalid", 32'(m_tvalid), 32'd1);
    chk("stalled_s_tready", 32'(s_tready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd1);
    s_tvalid = 1'b0;
    exp_q.delete();
    st_q.delete();
    cnt_model = '0;
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    rdy_mode = 0;
    pay_q = '{32'hE1, 32'hE2, 32'hE3};
    run_frame(GOOD, 16'd3, 0);
    drain();
    chk("post_reset_cnt", 32'(frame_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
